// File: rtl/baud_rate_ctrl.sv
// Baud path controller: holds the active divisor, defers divisor changes to bit boundaries,
// and generates the oversample (tick_os) and bit (tick_bit) ticks. Define BAUD_FRAC_EN for fractional divisors.
module baud_rate_ctrl #(
    parameter int DIV_W       = 16,
    parameter int OSR         = 16,
    parameter int DEFAULT_DIV = 54
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef BAUD_FRAC_EN
    input  logic [3:0]       cfg_frac,
    output logic [3:0]       cur_frac,
`endif
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             tick_os,
    output logic             tick_bit,
    output logic             busy
);

    localparam int               OS_W    = $clog2(OSR);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] period_m1;
    logic [OS_W-1:0]  os_cnt;
    logic             xfer;
    logic             accept;
    logic             reject;
    logic             run_cnt;
    logic             apply;
    logic             os_hit;
    logic             bit_hit;
    logic             load_req;
    logic             load_pend;
    logic             latch_pend;
    logic             ready_nxt;
    logic             busy_nxt;

    assign xfer    = cfg_valid & cfg_ready;
    assign accept  = xfer & (cfg_div >= DIV_MIN);
    assign reject  = xfer & (cfg_div < DIV_MIN);
    assign run_cnt = (state != IDLE) & enable;
    assign apply   = (state == PEND) & enable & tick_bit;
    assign os_hit  = run_cnt & (div_cnt == period_m1);
    assign bit_hit = os_hit & (os_cnt == OS_LAST);

    // A request accepted while idle (or while being disabled) takes effect directly;
    // in RUN it waits for the bit boundary so the tick stream never glitches.
    assign load_req   = accept & ((state == IDLE) | ((state == RUN) & ~enable));
    assign latch_pend = accept & (state == RUN) & enable;
    assign load_pend  = (state == PEND) & (~enable | tick_bit);

`ifdef BAUD_FRAC_EN
    logic [3:0] pend_frac;
    logic [3:0] phase_acc;
    logic [4:0] phase_sum;
    logic       stretch;

    assign phase_sum = {1'b0, phase_acc} + {1'b0, cur_frac};
    assign period_m1 = cur_div - DIV_ONE + {{(DIV_W-1){1'b0}}, stretch};
`else
    assign period_m1 = cur_div - DIV_ONE;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable)     state_nxt = IDLE;
                else if (accept) state_nxt = PEND;
            end
            PEND: begin
                if (!enable)       state_nxt = IDLE;
                else if (tick_bit) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = (state_nxt != PEND);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            cur_div   <= DIV_RST;
            pend_div  <= DIV_RST;
        end else begin
            cfg_ready <= ready_nxt;
            busy      <= busy_nxt;
            cfg_err   <= reject;
            if (latch_pend) begin
                pend_div <= cfg_div;
            end
            if (load_req) begin
                cur_div <= cfg_div;
            end else if (load_pend) begin
                cur_div <= pend_div;
            end
        end
    end

    // Counters restart from zero whenever counting is off or a new divisor lands.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end else if (!run_cnt || apply) begin
            div_cnt  <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end else begin
            tick_os  <= os_hit;
            tick_bit <= bit_hit;
            if (os_hit) begin
                div_cnt <= '0;
                os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end
        end
    end

`ifdef BAUD_FRAC_EN
    // Phase accumulator carry stretches the following oversample period by one cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            phase_acc <= '0;
            stretch   <= 1'b0;
        end else if (!run_cnt || apply) begin
            phase_acc <= '0;
            stretch   <= 1'b0;
        end else if (os_hit) begin
            phase_acc <= phase_sum[3:0];
            stretch   <= phase_sum[4];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cur_frac  <= '0;
            pend_frac <= '0;
        end else begin
            if (latch_pend) begin
                pend_frac <= cfg_frac;
            end
            if (load_req) begin
                cur_frac <= cfg_frac;
            end else if (load_pend) begin
                cur_frac <= pend_frac;
            end
        end
    end
`else
`endif

endmodule

// File: doc/baud_rate_ctrl.md
Name: baud_rate_ctrl

Overview:
Configuration and sequencing controller for the UART baud generator path. Holds the active clock divisor and accepts new divisor requests over a valid/ready handshake. Defers any change to the next bit boundary so tick streams never glitch. Produces the oversample tick (tick_os) and the bit tick (tick_bit) consumed by the UART TX/RX blocks.

Parameters:
DIV_W, 16, width of divisor and divide counter
OSR, 16, oversample ticks per bit (>=2)
DEFAULT_DIV, 54, divisor loaded at reset (100 MHz / (115200*16))

Ports:
clk_in  input  1  system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  run tick generation when high
cfg_valid  input  1  new divisor request
cfg_div  input  DIV_W  requested divisor (clk_in cycles per tick_os)
cfg_ready  output  1  controller can accept a request this cycle
cfg_err  output  1  one-cycle pulse: request rejected (cfg_div < 2)
cur_div  output  DIV_W  divisor currently in effect
tick_os  output  1  one-cycle oversample tick
tick_bit  output  1  one-cycle bit tick, coincident with every OSR-th tick_os
busy  output  1  high in RUN or PEND

Behaviour:
- Reset (rst_n low at clk_in edge) sets: cur_div=DEFAULT_DIV, div_cnt=0, os_cnt=0, tick_os=0, tick_bit=0, cfg_ready=1, cfg_err=0, busy=0, state IDLE. Reset dominates all other inputs, including mid-operation and with a pending request; the pending request is discarded.
- States: IDLE (enable=0), RUN, PEND (valid request latched, awaiting bit boundary).
- All outputs are registered.
- Handshake: a transfer occurs on an edge where cfg_valid & cfg_ready. cfg_ready=1 in IDLE and RUN, 0 in PEND.
- Rejected request (cfg_div < 2): cfg_err=1 for exactly the next cycle; no state or cur_div change.
- Valid request in IDLE: cur_div takes cfg_div on the next cycle.
- Valid request in RUN: latch pend_div, go to PEND.
- In PEND, on the cycle tick_bit is asserted: cur_div<=pend_div, div_cnt<=0, os_cnt<=0, state returns to RUN. The new period starts at the next cycle.
- Counting (RUN/PEND):
  - div_cnt counts 0..cur_div-1 and wraps.
  - tick_os=1 in the cycle after div_cnt==cur_div-1, giving a period of exactly cur_div clk_in cycles.
  - The first tick_os occurs cur_div cycles after the first edge sampling enable=1.
  - os_cnt increments on each tick_os and wraps at OSR-1.
  - tick_bit=1 together with the tick_os that wraps os_cnt, giving a period of cur_div*OSR cycles.
- enable falling: on the next edge go to IDLE, clear div_cnt and os_cnt, deassert ticks. If in PEND, apply pend_div immediately.
- Simultaneous enable rise and valid request in IDLE: cur_div takes the new value and counting starts with it.
- Simultaneous request and tick_bit in RUN: request is latched into PEND and applies at the following bit boundary, not the current one.
- Width: counters are DIV_W bits and os_cnt is clog2(OSR) bits. No overflow is possible since cfg_div is at most 2^DIV_W-1.

Optional Feature:
BAUD_FRAC_EN
- Defined:
  - Adds input cfg_frac[3:0], latched alongside cfg_div through the same handshake, plus output cur_frac.
  - A 4-bit phase accumulator adds cur_frac on every tick_os; on carry-out the next tick_os period is cur_div+1 cycles.
  - Mean period is cur_div + cur_frac/16.
  - Accumulator resets with rst_n, on disable, and when a new config applies.
- Undefined: no cfg_frac/cur_frac ports; integer division only.

Test Plan:
- Reset then enable=1, no cfg -> tick_os every 54 cycles; tick_bit every 864 cycles; cur_div=54; cfg_ready=1.
- IDLE: cfg_div=4 handshake, then enable -> tick_os period 4; tick_bit every 64 cycles; first tick_os 4 cycles after enable.
- RUN at div=4: request cfg_div=10 mid-bit -> cfg_ready low and busy high; period stays 4 until tick_bit, then period 10; cfg_ready returns high.
- Request cfg_div=1 and cfg_div=0 -> cfg_err pulses one cycle each; cur_div and tick period unchanged.
- PEND with pend_div=8, then enable=0 -> ticks stop next cycle and cur_div=8. Separately, assert rst_n=0 mid-PEND -> cur_div=54 and request discarded.
- With BAUD_FRAC_EN: cfg_div=4, cfg_frac=8 -> tick_os periods alternate 4,5; 32 tick_os span exactly 144 cycles.
